count_seq_ctrl: RTL and testbench
=================================

// Module: count_seq_ctrl
// PURPOSE
//  Command-driven sequencer for the W-bit up/down counter datapath (load/en/sel/q).
//  Accepts one {dir,start,end} command via valid/ready, loads start, then enables the
//  counter in dir until its output equals end, then pulses done.
//  Sits between a host/control FSM and one counter instance; the counter is external.
// PARAMETERS
//  W        4          counter / bound width in bits
//  TMO_CYC  2**W+4     RUN-phase watchdog limit in cycles (used only with COUNT_SEQ_TMO_EN)
// PORTS
//  clk        in   1  single clock, rising edge
//  reset      in   1  asynchronous, active-low reset
//  cmd_valid  in   1  command present
//  cmd_ready  out  1  controller can accept a command (high only in IDLE)
//  cmd_dir    in   1  1 = count up, 0 = count down
//  cmd_start  in   W  value loaded into counter
//  cmd_end    in   W  terminal value
//  abort      in   1  cancel current command
//  cnt_q      in   W  current counter output
//  cnt_load   out  1  load strobe to counter
//  cnt_d      out  W  load value to counter
//  cnt_en     out  1  count enable to counter
//  cnt_sel    out  1  direction to counter (1 = up)
//  busy       out  1  state != IDLE
//  done       out  1  one-cycle pulse: end reached
//  err        out  1  one-cycle pulse: watchdog expired (0 if COUNT_SEQ_TMO_EN undefined)
// BEHAVIOUR
//  - Interface: one clock clk; reset is asynchronous and active-low.
//  - Reset: state=IDLE; cnt_load=0, cnt_d=0, cnt_en=0, cnt_sel=0, busy=0, done=0, err=0;
//    cmd_ready=1 (IDLE). Reset mid-command drops it immediately; no done/err.
//  - States: IDLE -> LOAD -> RUN -> DONE -> IDLE.
//  - IDLE: cmd_ready=1. cmd_valid&cmd_ready at an edge latches dir/start/end; next LOAD.
//    abort ignored in IDLE.
//  - LOAD (1 cycle): cnt_load=1, cnt_d=start_r, cnt_sel=dir_r, cnt_en=0; next RUN.
//  - RUN: cnt_sel=dir_r; cnt_en = (cnt_q != end_r) & ~abort (combinational).
//    cnt_q==end_r -> cnt_en=0, next DONE. start==end -> zero steps, RUN lasts 1 cycle.
//  - DONE: done=1 for exactly one cycle, cnt_en=0; next IDLE. abort ignored in DONE.
//  - Latency: n = (end-start) mod 2**W if up, (start-end) mod 2**W if down;
//    handshake edge at cycle 0 -> LOAD cycle 1, RUN cycles 2..n+2, done high cycle n+3,
//    cmd_ready high again cycle n+4.
//  - Wrap-around: bounds compared modulo 2**W; up from 14 to 1 (W=4) passes 15,0 (3 steps).
//  - cnt_d and cnt_sel hold last values outside LOAD/RUN; cnt_load/cnt_en are 0.
//  - abort in LOAD or RUN: cnt_load/cnt_en forced 0 that cycle; next state IDLE; no done.
//    abort and match in the same RUN cycle: abort wins, no done.
//  - cmd_valid while busy: not accepted (cmd_ready=0); fields may change freely.
// CONFIGURATION
//  COUNT_SEQ_TMO_EN defined: RUN-cycle counter (clog2(TMO_CYC+1) bits) cleared on RUN
//    entry; after TMO_CYC RUN cycles without match -> cnt_en=0, err=1 one cycle, IDLE.
//    abort in the same cycle wins (no err). Match in the same cycle wins over timeout.
//  COUNT_SEQ_TMO_EN undefined: no watchdog logic; err tied 0; RUN waits indefinitely.
// TESTING  (bench drives cnt_q from a behavioural load/en/sel counter model, W=4)
//  1. reset low 2 cycles -> all outputs at reset values, cmd_ready=1, busy=0.
//  2. up, start=3, end=7 -> cnt_load one cycle with cnt_d=3; cnt_q 3,4,5,6,7;
//     done 7 cycles after handshake; exactly 4 cnt_en cycles.
//  3. down, start=2, end=14 -> cnt_q 2,1,0,15,14 (wrap); done after 4 steps; then
//     start=end=9 -> zero cnt_en cycles, done 3 cycles after handshake.
//  4. abort in 3rd RUN cycle of up 0->10 -> cnt_en 0 same cycle, IDLE next, no done;
//     cmd_valid held during RUN not accepted; accepted the cycle cmd_ready returns.
//  5. reset asserted during RUN -> cnt_en=0 immediately, no done; normal command after.
//  6. COUNT_SEQ_TMO_EN, model counter stuck -> err pulse after TMO_CYC=20 RUN cycles,
//     IDLE next; without macro -> err stays 0, busy stays 1.

Source files
------------

// File: rtl/count_seq_ctrl.sv
// Command sequencer driving an external load/en/sel up/down counter.
// Optional RUN-phase watchdog enabled by defining COUNT_SEQ_TMO_EN.
module count_seq_ctrl #(
    parameter int W       = 4,
    parameter int TMO_CYC = 2**W + 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_dir,
    input  logic [W-1:0] cmd_start,
    input  logic [W-1:0] cmd_end,
    input  logic         abort,
    input  logic [W-1:0] cnt_q,
    output logic         cnt_load,
    output logic [W-1:0] cnt_d,
    output logic         cnt_en,
    output logic         cnt_sel,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           dir_r;
    logic [W-1:0]   start_r;
    logic [W-1:0]   end_r;
    logic           match;
    logic           tmo_hit;

    assign match = (cnt_q == end_r);

`ifdef COUNT_SEQ_TMO_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    localparam logic [TW-1:0] TMO_LIM = TW'(TMO_CYC);

    logic [TW-1:0] run_cnt;

    // counts completed RUN cycles; held at zero outside RUN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cnt <= '0;
        end else if (state != RUN) begin
            run_cnt <= '0;
        end else if (run_cnt != TMO_LIM) begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    assign tmo_hit = (state == RUN) && (run_cnt == TMO_LIM);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            dir_r   <= 1'b0;
            start_r <= '0;
            end_r   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && cmd_valid) begin
                dir_r   <= cmd_dir;
                start_r <= cmd_start;
                end_r   <= cmd_end;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        err       = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid) state_nxt = LOAD;
            end
            LOAD: begin
                cnt_load  = ~abort;
                state_nxt = abort ? IDLE : RUN;
            end
            RUN: begin
                // priority: abort, then match, then watchdog
                if (abort) begin
                    state_nxt = IDLE;
                end else if (match) begin
                    state_nxt = DONE;
                end else if (tmo_hit) begin
                    err       = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // load value and direction stay on the last latched command
    assign cnt_d     = start_r;
    assign cnt_sel   = dir_r;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Self-checking bench for count_seq_ctrl with a behavioural counter on cnt_q.
// Command outcomes are predicted from modular step counts, not RTL state.
module tb_count_seq_ctrl;

    localparam int W = 4;
    localparam int M = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_dir = 1'b0;
    logic [W-1:0] cmd_start = '0;
    logic [W-1:0] cmd_end = '0;
    logic         abort = 1'b0;
    logic [W-1:0] cnt_q;
    logic         cnt_load;
    logic [W-1:0] cnt_d;
    logic         cnt_en;
    logic         cnt_sel;
    logic         busy;
    logic         done;
    logic         err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    count_seq_ctrl #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_start (cmd_start),
        .cmd_end   (cmd_end),
        .abort     (abort),
        .cnt_q     (cnt_q),
        .cnt_load  (cnt_load),
        .cnt_d     (cnt_d),
        .cnt_en    (cnt_en),
        .cnt_sel   (cnt_sel),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // external counter model; stuck freezes counting but not loading
    logic [W-1:0] q_m = '0;
    logic         stuck = 1'b0;

    always @(posedge clk) begin
        if (cnt_load) q_m <= cnt_d;
        else if (cnt_en && !stuck) q_m <= cnt_sel ? q_m + 1'b1 : q_m - 1'b1;
    end

    assign cnt_q = q_m;

    typedef struct {
        bit dir;
        int s;
        int e;
        int n;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int steps(input bit dir, input int s, input int e);
        return dir ? (e - s + M) % M : (s - e + M) % M;
    endfunction

    function automatic int exp_q(input bit dir, input int s, input int i);
        return dir ? (s + i) % M : (s - i + 4 * M) % M;
    endfunction

    task automatic issue(input bit dir, input int s, input int e);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_start = s[W-1:0];
        cmd_end   = e[W-1:0];
        #1;
        chk("issue ready", cmd_ready, 1);
    endtask

    // follows one accepted command from the cycle after its handshake edge
    task automatic follow(input string name, input bit dir, input int s,
                          input int e, input int n);
        int en_cnt  = 0;
        int done_at = -1;
        int qbad    = 0;
        int load_n  = 0;
        for (int k = 1; k <= 40 && done_at < 0; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #1;
            if (k == 1) begin
                chk({name, " load"}, cnt_load, 1);
                chk({name, " cnt_d"}, cnt_d, s);
                chk({name, " sel"}, cnt_sel, dir);
            end
            if (cnt_load) load_n++;
            if (cnt_en) en_cnt++;
            if (k >= 2 && k <= n + 2 && cnt_q !== exp_q(dir, s, k - 2)) qbad++;
            if (done) done_at = k;
        end
        chk({name, " done_at"}, done_at, n + 3);
        chk({name, " en_cycles"}, en_cnt, n);
        chk({name, " load_cycles"}, load_n, 1);
        chk({name, " q_seq_bad"}, qbad, 0);
        chk({name, " q_end"}, cnt_q, e);
        @(negedge clk);
        #1;
        chk({name, " ready_after"}, cmd_ready, 1);
        chk({name, " done_after"}, done, 0);
        chk({name, " d_hold"}, cnt_d, s);
        chk({name, " sel_hold"}, cnt_sel, dir);
    endtask

    initial begin
        vec_t tbl[6];
        int   err_at;
        int   busy_end;
        int   dn;
        tbl[0] = '{1'b1, 3, 7, 4};
        tbl[1] = '{1'b0, 2, 14, 4};
        tbl[2] = '{1'b1, 9, 9, 0};
        tbl[3] = '{1'b1, 14, 1, 3};
        tbl[4] = '{1'b0, 0, 15, 1};
        tbl[5] = '{1'b0, 5, 6, 15};

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst ready", cmd_ready, 1);
        chk("rst busy", busy, 0);
        chk("rst load", cnt_load, 0);
        chk("rst d", cnt_d, 0);
        chk("rst en", cnt_en, 0);
        chk("rst sel", cnt_sel, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            issue(tbl[i].dir, tbl[i].s, tbl[i].e);
            follow($sformatf("vec%0d", i), tbl[i].dir, tbl[i].s, tbl[i].e,
                   tbl[i].n);
        end

        // abort in third RUN cycle while a second command waits
        issue(1'b1, 0, 10);
        dn = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_dir   = 1'b1;
            cmd_start = 4'd5;
            cmd_end   = 4'd6;
            #1;
            if (cmd_ready) dn++;
            if (done) dn++;
        end
        chk("abort busy_phase", dn, 0);
        @(negedge clk);
        abort = 1'b1;
        #1;
        chk("abort en", cnt_en, 0);
        chk("abort busy", busy, 1);
        chk("abort done", done, 0);
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abort idle_ready", cmd_ready, 1);
        chk("abort idle_done", done, 0);
        chk("abort q_frozen", cnt_q, 2);
        follow("post_abort", 1'b1, 5, 6, 1);

        // reset asserted during RUN
        issue(1'b1, 0, 10);
        repeat (3) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstrun en", cnt_en, 0);
        chk("rstrun busy", busy, 0);
        chk("rstrun done", done, 0);
        chk("rstrun ready", cmd_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        issue(1'b0, 4, 1);
        follow("post_rst", 1'b0, 4, 1, 3);

        // stuck counter: watchdog or indefinite wait
        stuck  = 1'b1;
        err_at = -1;
        busy_end = -1;
        issue(1'b1, 0, 5);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #1;
            if (err && err_at < 0) err_at = k;
            if (k == 30) busy_end = busy;
        end
`ifdef COUNT_SEQ_TMO_EN
        chk("tmo err_at", err_at, 22);
        chk("tmo busy_end", busy_end, 0);
`else
        chk("tmo err_at", err_at, -1);
        chk("tmo busy_end", busy_end, 1);
`endif
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        stuck = 1'b0;
        #1;
        chk("tmo recover", cmd_ready, 1);

        // randomized commands against the modular step model
        for (int r = 0; r < 25; r++) begin
            bit dir;
            int s;
            int e;
            dir = 1'($urandom_range(0, 1));
            s   = $urandom_range(0, M - 1);
            e   = $urandom_range(0, M - 1);
            issue(dir, s, e);
            follow($sformatf("rnd%0d", r), dir, s, e, steps(dir, s, e));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
